dispatch_stage: RTL and testbench

//  Dispatch stage between decode/rename and the reservation station (RS). Buffers renamed

---
 rtl/dispatch_stage_if.sv | 51 +++++
 rtl/dispatch_stage.sv | 129 ++++++++++++
 tb/tb_dispatch_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_stage_if.sv
// Dispatch stage bus: decode-side instruction handshake, flush, RS free flags,
// CDB broadcast and the RS allocation outputs.
//   master : drives decode/flush/free/CDB inputs, observes allocation outputs
//   slave  : the dispatch stage itself
interface dispatch_stage_if #(
  parameter int TAG_W = 5
);
  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [31:0]      dec_pc_i;
  logic [31:0]      dec_inst_i;
  logic [TAG_W-1:0] dec_prs1_addr_i;
  logic [TAG_W-1:0] dec_prs2_addr_i;
  logic [TAG_W-1:0] dec_prd_addr_i;
  logic             dec_rd_wen_i;
  logic             flush_i;
  logic             alu_free_i;
  logic             lsu_free_i;
  logic             mul_free_i;
  logic             cdb_en_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic             rs_allocate_o;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic [TAG_W-1:0] prs1_addr_o;
  logic [TAG_W-1:0] prs2_addr_o;
  logic [TAG_W-1:0] prd_addr_o;
  logic             prs1_valid_o;
  logic             prs2_valid_o;
  logic             alu_request_o;
  logic             lsu_request_o;
  logic             mul_request_o;

  modport slave (
    input  dec_valid_i, dec_pc_i, dec_inst_i, dec_prs1_addr_i, dec_prs2_addr_i,
           dec_prd_addr_i, dec_rd_wen_i, flush_i, alu_free_i, lsu_free_i,
           mul_free_i, cdb_en_i, cdb_tag_i,
    output dec_ready_o, rs_allocate_o, pc_o, inst_o, prs1_addr_o, prs2_addr_o,
           prd_addr_o, prs1_valid_o, prs2_valid_o, alu_request_o,
           lsu_request_o, mul_request_o
  );

  modport master (
    output dec_valid_i, dec_pc_i, dec_inst_i, dec_prs1_addr_i, dec_prs2_addr_i,
           dec_prd_addr_i, dec_rd_wen_i, flush_i, alu_free_i, lsu_free_i,
           mul_free_i, cdb_en_i, cdb_tag_i,
    input  dec_ready_o, rs_allocate_o, pc_o, inst_o, prs1_addr_o, prs2_addr_o,
           prd_addr_o, prs1_valid_o, prs2_valid_o, alu_request_o,
           lsu_request_o, mul_request_o
  );
endinterface

// File: rtl/dispatch_stage.sv
// Dispatch stage: 2-entry in-order FIFO between rename and the reservation
// stations. Classifies the head to ALU/LSU/MUL, tracks a per-physical-register
// busy table fed by the CDB, and allocates the head into its RS when that RS
// has room.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : dispatch_stage_if.slave (decode push, flush, RS free flags,
//             CDB, head fields, source-ready bits, FU class, allocate)
module dispatch_stage #(
  parameter int PREG_NUM = 32,
  parameter int TAG_W    = 5,
  parameter int Q_DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  dispatch_stage_if.slave   bus
);

  // FIFO state; full/empty come from the count, never from pointer compare
  logic [1:0]          r_cnt;
  logic                r_wptr, r_rptr;
  logic [31:0]         r_pc   [Q_DEPTH];
  logic [31:0]         r_inst [Q_DEPTH];
  logic [TAG_W-1:0]    r_prs1 [Q_DEPTH];
  logic [TAG_W-1:0]    r_prs2 [Q_DEPTH];
  logic [TAG_W-1:0]    r_prd  [Q_DEPTH];
  logic                r_wen  [Q_DEPTH];
  logic [PREG_NUM-1:0] r_busy;

  logic                w_empty, w_full, w_push, w_alloc, w_free;
  logic [31:0]         w_h_inst;
  logic [TAG_W-1:0]    w_h_prs1, w_h_prs2, w_h_prd;
  logic [6:0]          w_op, w_f7;
  logic                w_is_lsu, w_is_mul, w_is_alu;
  logic                w_rdy1, w_rdy2;
  logic [PREG_NUM-1:0] w_busy_nxt;

  assign w_empty  = (r_cnt == 2'd0);
  assign w_full   = (r_cnt == 2'(Q_DEPTH));
  assign w_h_inst = r_inst[r_rptr];
  assign w_h_prs1 = r_prs1[r_rptr];
  assign w_h_prs2 = r_prs2[r_rptr];
  assign w_h_prd  = r_prd[r_rptr];

  // FU class of the head: loads/stores to LSU, RV32M (OP + funct7=1) to MUL
  assign w_op     = w_h_inst[6:0];
  assign w_f7     = w_h_inst[31:25];
  assign w_is_lsu = (w_op == 7'b0000011) || (w_op == 7'b0100011);
  assign w_is_mul = (w_op == 7'b0110011) && (w_f7 == 7'b0000001);
  assign w_is_alu = !w_is_lsu && !w_is_mul;
  assign w_free   = (w_is_lsu & bus.lsu_free_i) | (w_is_mul & bus.mul_free_i) |
                    (w_is_alu & bus.alu_free_i);

  assign w_alloc  = !w_empty && w_free && !bus.flush_i;
  assign w_push   = bus.dec_valid_i && !w_full && !bus.flush_i;

  // Source ready reads the busy table before this edge's update; a matching
  // CDB broadcast in the same cycle is bypassed in
  assign w_rdy1 = (w_h_prs1 == '0) || !r_busy[w_h_prs1] ||
                  (bus.cdb_en_i && (bus.cdb_tag_i == w_h_prs1));
  assign w_rdy2 = (w_h_prs2 == '0) || !r_busy[w_h_prs2] ||
                  (bus.cdb_en_i && (bus.cdb_tag_i == w_h_prs2));

  // Clear from CDB first, then set from allocation so a new producer of the
  // same tag wins; tag 0 is the hardwired zero register and never busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.cdb_en_i) w_busy_nxt[bus.cdb_tag_i] = 1'b0;
    if (w_alloc && r_wen[r_rptr] && (w_h_prd != '0)) w_busy_nxt[w_h_prd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_busy <= '0;
    end else begin
      if (w_push)  r_wptr <= ~r_wptr;
      if (w_alloc) r_rptr <= ~r_rptr;
      if (w_push && !w_alloc)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_alloc) r_cnt <= r_cnt - 2'd1;
      r_busy <= w_busy_nxt;
    end
  end

  // Entry payload needs no reset; it is only observed while counted valid
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) begin
      r_pc[r_wptr]   <= bus.dec_pc_i;
      r_inst[r_wptr] <= bus.dec_inst_i;
      r_prs1[r_wptr] <= bus.dec_prs1_addr_i;
      r_prs2[r_wptr] <= bus.dec_prs2_addr_i;
      r_prd[r_wptr]  <= bus.dec_prd_addr_i;
      r_wen[r_wptr]  <= bus.dec_rd_wen_i;
    end
  end

  // Outputs are forced to zero while empty so downstream sees clean values
  always_comb begin
    bus.dec_ready_o   = !w_full;
    bus.rs_allocate_o = w_alloc;
    bus.pc_o          = '0;
    bus.inst_o        = '0;
    bus.prs1_addr_o   = '0;
    bus.prs2_addr_o   = '0;
    bus.prd_addr_o    = '0;
    bus.prs1_valid_o  = 1'b0;
    bus.prs2_valid_o  = 1'b0;
    bus.alu_request_o = 1'b0;
    bus.lsu_request_o = 1'b0;
    bus.mul_request_o = 1'b0;
    if (!w_empty) begin
      bus.pc_o          = r_pc[r_rptr];
      bus.inst_o        = w_h_inst;
      bus.prs1_addr_o   = w_h_prs1;
      bus.prs2_addr_o   = w_h_prs2;
      bus.prd_addr_o    = w_h_prd;
      bus.prs1_valid_o  = w_rdy1;
      bus.prs2_valid_o  = w_rdy2;
      bus.alu_request_o = w_is_alu;
      bus.lsu_request_o = w_is_lsu;
      bus.mul_request_o = w_is_mul;
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
module tb_dispatch_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_stage_if #(.TAG_W(5)) ifc ();
  dispatch_stage #(.PREG_NUM(32), .TAG_W(5), .Q_DEPTH(2)) dut (
    .clk_i(clk), .reset_i(rst), .bus(ifc));

  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_SUB = 32'h4000_0033;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_MUL = 32'h0200_0033;

  typedef struct {
    bit v; logic [31:0] pc, inst; logic [4:0] p1, p2, pd; bit wen;
    bit fl, af, lf, mf, ce; logic [4:0] ct;
  } stim_t;

  typedef struct packed {
    logic ready, alloc, alu, lsu, mul, v1, v2;
    logic [31:0] pc, inst; logic [4:0] p1, p2, pd;
  } out_t;

  typedef struct packed {
    logic [31:0] pc, inst; logic [4:0] p1, p2, pd; logic wen;
  } ent_t;

  // Reference: FIFO as a queue, busy table as a bit per register
  ent_t     q[$];
  bit [31:0] mbusy;
  int n_vec = 0, n_err = 0;

  function automatic stim_t idle();
    stim_t s;
    s.v = 0; s.pc = '0; s.inst = '0; s.p1 = '0; s.p2 = '0; s.pd = '0; s.wen = 0;
    s.fl = 0; s.af = 0; s.lf = 0; s.mf = 0; s.ce = 0; s.ct = '0;
    return s;
  endfunction

  function automatic stim_t ins(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [4:0] p1, input logic [4:0] p2,
                                input logic [4:0] pd);
    stim_t s = idle();
    s.v = 1; s.pc = pc; s.inst = inst; s.p1 = p1; s.p2 = p2; s.pd = pd; s.wen = 1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ifc.dec_valid_i = s.v;  ifc.dec_pc_i = s.pc; ifc.dec_inst_i = s.inst;
    ifc.dec_prs1_addr_i = s.p1; ifc.dec_prs2_addr_i = s.p2;
    ifc.dec_prd_addr_i = s.pd; ifc.dec_rd_wen_i = s.wen; ifc.flush_i = s.fl;
    ifc.alu_free_i = s.af; ifc.lsu_free_i = s.lf; ifc.mul_free_i = s.mf;
    ifc.cdb_en_i = s.ce; ifc.cdb_tag_i = s.ct;
  endtask

  function automatic bit src_ok(input logic [4:0] t);
    return (t == 0) || !mbusy[t] || (ifc.cdb_en_i && ifc.cdb_tag_i == t);
  endfunction

  function automatic out_t model_out();
    out_t o = '0;
    o.ready = (q.size() < 2);
    if (q.size() > 0) begin
      ent_t h = q[0];
      bit ld_st = (h.inst[6:0] == 7'h03) || (h.inst[6:0] == 7'h23);
      bit mulop = (h.inst[6:0] == 7'h33) && (h.inst[31:25] == 7'h01);
      o.lsu = ld_st; o.mul = mulop; o.alu = !ld_st && !mulop;
      o.alloc = !ifc.flush_i && (ld_st ? ifc.lsu_free_i :
                                 mulop ? ifc.mul_free_i : ifc.alu_free_i);
      o.pc = h.pc; o.inst = h.inst; o.p1 = h.p1; o.p2 = h.p2; o.pd = h.pd;
      o.v1 = src_ok(h.p1); o.v2 = src_ok(h.p2);
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.ready = ifc.dec_ready_o; o.alloc = ifc.rs_allocate_o;
    o.alu = ifc.alu_request_o; o.lsu = ifc.lsu_request_o; o.mul = ifc.mul_request_o;
    o.v1 = ifc.prs1_valid_o; o.v2 = ifc.prs2_valid_o;
    o.pc = ifc.pc_o; o.inst = ifc.inst_o;
    o.p1 = ifc.prs1_addr_o; o.p2 = ifc.prs2_addr_o; o.pd = ifc.prd_addr_o;
    return o;
  endfunction

  task automatic model_step();
    out_t e = model_out();
    if (rst || ifc.flush_i) begin
      q.delete(); mbusy = '0;
    end else begin
      if (ifc.cdb_en_i) mbusy[ifc.cdb_tag_i] = 1'b0;
      if (e.alloc) begin
        if (q[0].wen && q[0].pd != 0) mbusy[q[0].pd] = 1'b1;
        void'(q.pop_front());
      end
      if (ifc.dec_valid_i && e.ready)
        q.push_back('{ifc.dec_pc_i, ifc.dec_inst_i, ifc.dec_prs1_addr_i,
                      ifc.dec_prs2_addr_i, ifc.dec_prd_addr_i, ifc.dec_rd_wen_i});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s = ins(32'h40, I_ADD, 1, 2, 3);
    out_t e, o;
    rst = 1; apply(idle()); tick(); tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      rst = (i == 3);
      apply(i < 3 ? s : idle());
      #1; e = model_out(); o = dut_out();
      if (i != 0 && i != 4) begin
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset c%0d got=%h exp=%h", i, o, e); end
      end
      if (i == 0 || i == 4) begin
        n_vec++;
        if ({o.ready, o.alloc, o.alu, o.lsu, o.mul} !== 5'b10000) begin
          n_err++; $display("FAIL reset_state c%0d got=%b exp=10000", i,
                            {o.ready, o.alloc, o.alu, o.lsu, o.mul});
        end
      end
      if (i == 2) begin
        n_vec++;
        if (o.ready !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", o.ready); end
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_alu_cdb();
    stim_t s[$]; stim_t b; out_t e, o;
    b = ins(32'h100, I_ADD, 3, 4, 5); b.af = 1; s.push_back(b);
    b = ins(32'h104, I_SUB, 5, 4, 6); b.af = 1; s.push_back(b);
    b = idle(); s.push_back(b);
    b = idle(); b.af = 1; b.ce = 1; b.ct = 5; s.push_back(b);
    b = ins(32'h108, I_ADD, 5, 0, 8); s.push_back(b);
    b = idle(); b.af = 1; s.push_back(b);
    foreach (s[i]) begin
      apply(s[i]); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL alu_cdb c%0d got=%h exp=%h", i, o, e); end
      case (i)
        1: begin n_vec++;
          if ({o.alloc, o.alu, o.v1, o.v2} !== 4'b1111) begin
            n_err++; $display("FAIL add_alloc got=%b exp=1111", {o.alloc, o.alu, o.v1, o.v2}); end
        end
        2: begin n_vec++;
          if (o.v1 !== 1'b0) begin n_err++; $display("FAIL sub_busy got=%b exp=0", o.v1); end
        end
        3: begin n_vec++;
          if ({o.alloc, o.v1} !== 2'b11) begin
            n_err++; $display("FAIL cdb_bypass got=%b exp=11", {o.alloc, o.v1}); end
        end
        5: begin n_vec++;
          if (o.v1 !== 1'b1) begin n_err++; $display("FAIL busy_clear got=%b exp=1", o.v1); end
        end
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_stall_order();
    stim_t list[3]; stim_t b; out_t e, o; int k = 0;
    list[0] = ins(32'h200, I_LW, 1, 0, 10);
    list[1] = ins(32'h204, I_ADD, 2, 0, 11);
    list[2] = ins(32'h208, I_ADD, 3, 0, 12);
    for (int c = 0; c < 8; c++) begin
      b = (k < 3) ? list[k] : idle();
      b.af = 1; b.lf = (c >= 4);
      apply(b); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL stall c%0d got=%h exp=%h", c, o, e); end
      case (c)
        2: begin n_vec++;
          if ({o.ready, o.alloc} !== 2'b00) begin
            n_err++; $display("FAIL full_stall got=%b exp=00", {o.ready, o.alloc}); end
        end
        4: begin n_vec++;
          if ({o.alloc, o.lsu, o.pc} !== {2'b11, 32'h200}) begin
            n_err++; $display("FAIL order_lw got=%h exp=%h", {o.alloc, o.lsu, o.pc}, {2'b11, 32'h200}); end
        end
        5: begin n_vec++;
          if ({o.alloc, o.alu, o.pc} !== {2'b11, 32'h204}) begin
            n_err++; $display("FAIL order_add1 got=%h exp=%h", {o.alloc, o.alu, o.pc}, {2'b11, 32'h204}); end
        end
        6: begin n_vec++;
          if ({o.alloc, o.pc} !== {1'b1, 32'h208}) begin
            n_err++; $display("FAIL order_add2 got=%h exp=%h", {o.alloc, o.pc}, {1'b1, 32'h208}); end
        end
        default: ;
      endcase
      if (b.v && e.ready) k++;
      tick();
    end
  endtask

  task automatic test_set_wins();
    stim_t s[$]; stim_t b; out_t e, o;
    b = ins(32'h300, I_MUL, 1, 2, 7); s.push_back(b);
    b = idle(); b.mf = 1; b.ce = 1; b.ct = 7; s.push_back(b);
    b = ins(32'h304, I_ADD, 7, 0, 14); s.push_back(b);
    b = idle(); s.push_back(b);
    b = idle(); b.af = 1; b.ce = 1; b.ct = 7; s.push_back(b);
    foreach (s[i]) begin
      apply(s[i]); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL set_wins c%0d got=%h exp=%h", i, o, e); end
      if (i == 1) begin n_vec++;
        if ({o.alloc, o.mul} !== 2'b11) begin
          n_err++; $display("FAIL mul_alloc got=%b exp=11", {o.alloc, o.mul}); end
      end
      if (i == 3) begin n_vec++;
        if (o.v1 !== 1'b0) begin n_err++; $display("FAIL set_priority got=%b exp=0", o.v1); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    stim_t s[$]; stim_t b; out_t e, o;
    b = ins(32'h400, I_ADD, 0, 0, 9); b.af = 1; s.push_back(b);
    b = ins(32'h404, I_ADD, 9, 0, 13); b.af = 1; s.push_back(b);
    b = ins(32'h408, I_ADD, 9, 0, 15); s.push_back(b);
    b = ins(32'h40c, I_ADD, 1, 0, 16); b.fl = 1; b.af = 1; s.push_back(b);
    b = ins(32'h410, I_ADD, 9, 0, 17); s.push_back(b);
    b = idle(); b.af = 1; s.push_back(b);
    foreach (s[i]) begin
      apply(s[i]); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL flush c%0d got=%h exp=%h", i, o, e); end
      case (i)
        3: begin n_vec++;
          if ({o.ready, o.alloc} !== 2'b00) begin
            n_err++; $display("FAIL flush_noalloc got=%b exp=00", {o.ready, o.alloc}); end
        end
        4: begin n_vec++;
          if ({o.ready, o.alloc, o.alu} !== 3'b100) begin
            n_err++; $display("FAIL flush_empty got=%b exp=100", {o.ready, o.alloc, o.alu}); end
        end
        5: begin n_vec++;
          if ({o.pc, o.v1} !== {32'h410, 1'b1}) begin
            n_err++; $display("FAIL flush_busy_clr got=%h exp=%h", {o.pc, o.v1}, {32'h410, 1'b1}); end
        end
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_prd0();
    stim_t s[$]; stim_t b; out_t e, o;
    b = ins(32'h500, I_ADD, 1, 2, 0); b.af = 1; s.push_back(b);
    b = idle(); b.af = 1; s.push_back(b);
    b = ins(32'h504, I_SUB, 0, 0, 18); s.push_back(b);
    b = idle(); b.af = 1; s.push_back(b);
    foreach (s[i]) begin
      apply(s[i]); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL prd0 c%0d got=%h exp=%h", i, o, e); end
      if (i == 3) begin n_vec++;
        if ({o.alloc, o.v1, o.v2} !== 3'b111) begin
          n_err++; $display("FAIL zero_reg got=%b exp=111", {o.alloc, o.v1, o.v2}); end
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op, f7;
    case ($urandom_range(0, 4))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      default: op = 7'($urandom);
    endcase
    f7 = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom);
    return {f7, 18'($urandom), op};
  endfunction

  task automatic test_random();
    stim_t b; out_t e, o;
    for (int c = 0; c < 600; c++) begin
      b = idle();
      b.v = ($urandom_range(0, 2) != 0);
      b.pc = $urandom; b.inst = rnd_inst();
      b.p1 = 5'($urandom_range(0, 7)); b.p2 = 5'($urandom_range(0, 7));
      b.pd = 5'($urandom_range(0, 7)); b.wen = ($urandom_range(0, 3) != 0);
      b.fl = ($urandom_range(0, 19) == 0);
      b.af = ($urandom_range(0, 3) != 0); b.lf = ($urandom_range(0, 3) != 0);
      b.mf = ($urandom_range(0, 3) != 0);
      b.ce = ($urandom_range(0, 1) == 1); b.ct = 5'($urandom_range(0, 7));
      apply(b); #1; e = model_out(); o = dut_out();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random c%0d got=%h exp=%h", c, o, e); end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    apply(idle());
    test_reset();
    test_alu_cdb();
    test_stall_order();
    test_set_wins();
    test_flush();
    test_prd0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
